// File: rtl/sid_pkg.sv
// Shared constants, types and the address decoder for the SID register bank.
package sid_pkg;

    localparam int REGS_PER_VOICE = 7;

    typedef enum logic [2:0] {
        FREQ_LO = 3'd0,
        FREQ_HI = 3'd1,
        PW_LO   = 3'd2,
        PW_HI   = 3'd3,
        CONTROL = 3'd4,
        A_D     = 3'd5,
        S_R     = 3'd6
    } voice_reg_e;

    localparam logic [2:0] FC_LO_OFF    = 3'd0;
    localparam logic [2:0] FC_HI_OFF    = 3'd1;
    localparam logic [2:0] RES_FILT_OFF = 3'd2;
    localparam logic [2:0] MODE_VOL_OFF = 3'd3;
    localparam logic [2:0] POTX_OFF     = 3'd4;
    localparam logic [2:0] POTY_OFF     = 3'd5;
    localparam logic [2:0] OSC3_OFF     = 3'd6;
    localparam logic [2:0] ENV3_OFF     = 3'd7;

    typedef enum logic [1:0] {
        REGION_VOICE    = 2'd0,
        REGION_FILTER   = 2'd1,
        REGION_RO       = 2'd2,
        REGION_UNMAPPED = 2'd3
    } region_e;

    typedef struct packed {
        region_e    region;
        logic [2:0] voice;
        logic [2:0] index;
    } addr_dec_t;

    // Filter and read-only indices are offsets from the end of the voice block.
    function automatic addr_dec_t sid_decode(input logic [7:0] addr, input int unsigned num_voices);
        int unsigned a;
        int unsigned base;
        addr_dec_t   d;
        a        = {24'd0, addr};
        base     = 32'd7 * num_voices;
        d.region = REGION_UNMAPPED;
        d.voice  = 3'd0;
        d.index  = 3'd0;
        if (a < base) begin
            d.region = REGION_VOICE;
            d.voice  = 3'(a / 32'd7);
            d.index  = 3'(a % 32'd7);
        end else if (a < base + 32'd4) begin
            d.region = REGION_FILTER;
            d.index  = 3'(a - base);
        end else if (a < base + 32'd8) begin
            d.region = REGION_RO;
            d.index  = 3'(a - base);
        end else begin
            d.region = REGION_UNMAPPED;
        end
        return d;
    endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// Data-bus latch: holds the last written byte until the decay counter runs out.
module sid_bus_latch #(
    parameter int DECAY_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int CNT_W = $clog2(DECAY_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       dout_r;

    // Reload on any write; otherwise count down and clear on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            dout_r <= 8'h00;
        end else if (load) begin
            cnt_r  <= CNT_W'(DECAY_CYCLES);
            dout_r <= din;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                dout_r <= 8'h00;
            end else begin
                dout_r <= dout_r;
            end
        end else begin
            cnt_r  <= cnt_r;
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/sid_reg_bank.sv
// SID-style register bank: write-only voice/filter registers, read-only sources,
// a decaying bus latch for reads of write-only addresses, and gate-edge pulses.
module sid_reg_bank
    import sid_pkg::*;
#(
    parameter  int NUM_VOICES   = 3,
    parameter  int DECAY_CYCLES = 200000,
    localparam int NUM_REGS     = 7 * NUM_VOICES + 8,
    localparam int ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [ADDR_W-1:0]       w_addr,
    input  logic [7:0]              w_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    input  logic [7:0]              potx,
    input  logic [7:0]              poty,
    input  logic [7:0]              osc3,
    input  logic [7:0]              env3,
    output logic [NUM_VOICES*56-1:0] voice_regs,
    output logic [31:0]             filter_regs,
    output logic [NUM_VOICES-1:0]   gate_rise,
    output logic [NUM_VOICES-1:0]   gate_fall
);

    addr_dec_t               wr_dec_s;
    addr_dec_t               rd_dec_s;
    logic [7:0]              latch_s;
    logic [7:0]              rd_src_s;
    logic [NUM_VOICES*56-1:0] voice_regs_r;
    logic [31:0]             filter_regs_r;
    logic [NUM_VOICES-1:0]   gate_rise_r;
    logic [NUM_VOICES-1:0]   gate_fall_r;
    logic [7:0]              rd_data_r;
    logic                    rd_valid_r;

    assign wr_dec_s = sid_decode(8'(w_addr), NUM_VOICES);
    assign rd_dec_s = sid_decode(8'(rd_addr), NUM_VOICES);

    sid_bus_latch #(
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_bus_latch (
        .clk  (clk),
        .rst  (rst),
        .load (w_en),
        .din  (w_data),
        .dout (latch_s)
    );

    // Read source: live inputs for read-only offsets, bus latch for everything else.
    always_comb begin
        rd_src_s = latch_s;
        case (rd_dec_s)
            {REGION_RO, 3'd0, POTX_OFF}: rd_src_s = potx;
            {REGION_RO, 3'd0, POTY_OFF}: rd_src_s = poty;
            {REGION_RO, 3'd0, OSC3_OFF}: rd_src_s = osc3;
            {REGION_RO, 3'd0, ENV3_OFF}: rd_src_s = env3;
            default:                     rd_src_s = latch_s;
        endcase
    end

    // Register writes and gate-edge detection against the pre-write control byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            voice_regs_r  <= '0;
            filter_regs_r <= 32'h0000_0000;
            gate_rise_r   <= '0;
            gate_fall_r   <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                gate_rise_r[v] <= 1'b0;
                gate_fall_r[v] <= 1'b0;
                for (int k = 0; k < REGS_PER_VOICE; k++) begin
                    if (w_en && wr_dec_s.region == REGION_VOICE &&
                        wr_dec_s.voice == 3'(v) && wr_dec_s.index == 3'(k)) begin
                        voice_regs_r[(7*v+k)*8 +: 8] <= w_data;
                        if (3'(k) == CONTROL) begin
                            gate_rise_r[v] <= w_data[0] & ~voice_regs_r[(7*v+4)*8];
                            gate_fall_r[v] <= ~w_data[0] & voice_regs_r[(7*v+4)*8];
                        end else begin
                            gate_rise_r[v] <= 1'b0;
                            gate_fall_r[v] <= 1'b0;
                        end
                    end else begin
                        voice_regs_r[(7*v+k)*8 +: 8] <= voice_regs_r[(7*v+k)*8 +: 8];
                    end
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (w_en && wr_dec_s.region == REGION_FILTER && wr_dec_s.index == 3'(j)) begin
                    filter_regs_r[j*8 +: 8] <= w_data;
                end else begin
                    filter_regs_r[j*8 +: 8] <= filter_regs_r[j*8 +: 8];
                end
            end
        end
    end

    // One-cycle read pipeline; rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'h00;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data_r <= rd_src_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign voice_regs  = voice_regs_r;
    assign filter_regs = filter_regs_r;
    assign gate_rise   = gate_rise_r;
    assign gate_fall   = gate_fall_r;
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;

endmodule

// File: tb/tb_sid_reg_bank.sv
// Directed self-checking bench for sid_reg_bank (3 voices, 16-cycle bus decay).
module tb_sid_reg_bank;

    localparam int NV     = 3;
    localparam int DECAY  = 16;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [7:0]        potx, poty, osc3, env3;
    logic [NV*56-1:0]  voice_regs;
    logic [31:0]       filter_regs;
    logic [NV-1:0]     gate_rise;
    logic [NV-1:0]     gate_fall;

    logic [NV*56-1:0]  exp_voice;
    logic [31:0]       exp_filter;
    int                checks;
    int                errors;

    sid_reg_bank #(
        .NUM_VOICES   (NV),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .potx        (potx),
        .poty        (poty),
        .osc3        (osc3),
        .env3        (env3),
        .voice_regs  (voice_regs),
        .filter_regs (filter_regs),
        .gate_rise   (gate_rise),
        .gate_fall   (gate_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check_val({tag, "_valid"}, 192'(rd_valid), 192'(1'b1));
        check_val({tag, "_data"}, 192'(rd_data), 192'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = 8'h00;
        rd_en = 1'b0; rd_addr = '0;
        potx = 8'h00; poty = 8'h00; osc3 = 8'h00; env3 = 8'h00;
        exp_voice  = '0;
        exp_filter = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_voice", 192'(voice_regs), 192'(exp_voice));
        check_val("rst_filter", 192'(filter_regs), 192'(exp_filter));
        check_val("rst_valid", 192'(rd_valid), 192'(1'b0));
        check_val("rst_rdata", 192'(rd_data), 192'(8'h00));
        check_val("rst_gates", 192'({gate_rise, gate_fall}), 192'(6'b0));

        // Voice and filter writes
        do_write(5'd8, 8'h5A);
        exp_voice[8*8 +: 8] = 8'h5A;
        check_val("wr_voice8", 192'(voice_regs), 192'(exp_voice));
        do_write(5'd21, 8'hAB);
        do_write(5'd24, 8'hCD);
        exp_filter = 32'hCD00_00AB;
        check_val("wr_filter", 192'(filter_regs), 192'(exp_filter));

        // Read-only sources, write to read-only and unmapped addresses
        potx = 8'h33; osc3 = 8'h9C; env3 = 8'hE1;
        do_read("rd_potx", 5'd25, 8'h33);
        tick();
        check_val("hold_valid", 192'(rd_valid), 192'(1'b0));
        check_val("hold_data", 192'(rd_data), 192'(8'h33));
        do_write(5'd25, 8'h77);
        check_val("ro_wr_voice", 192'(voice_regs), 192'(exp_voice));
        check_val("ro_wr_filter", 192'(filter_regs), 192'(exp_filter));
        do_read("rd_latch77", 5'd0, 8'h77);
        do_write(5'd30, 8'h5F);
        check_val("unm_wr_voice", 192'(voice_regs), 192'(exp_voice));
        do_read("rd_unmapped", 5'd31, 8'h5F);
        rd_en = 1'b1; rd_addr = 5'd27;
        tick();
        check_val("b2b_osc3_valid", 192'(rd_valid), 192'(1'b1));
        check_val("b2b_osc3_data", 192'(rd_data), 192'(8'h9C));
        rd_addr = 5'd28;
        tick();
        rd_en = 1'b0;
        check_val("b2b_env3_valid", 192'(rd_valid), 192'(1'b1));
        check_val("b2b_env3_data", 192'(rd_data), 192'(8'hE1));

        // Bus-latch decay boundaries
        do_write(5'd22, 8'hC4);
        exp_filter[8 +: 8] = 8'hC4;
        check_val("wr_fchi", 192'(filter_regs), 192'(exp_filter));
        repeat (15) tick();
        do_read("decay15", 5'd3, 8'hC4);
        do_write(5'd22, 8'hC4);
        repeat (16) tick();
        do_read("decay16", 5'd3, 8'h00);
        do_write(5'd22, 8'hC4);
        repeat (15) tick();
        do_write(5'd22, 8'hD7);
        exp_filter[8 +: 8] = 8'hD7;
        do_read("decay_reload", 5'd3, 8'hD7);
        check_val("reload_filter", 192'(filter_regs), 192'(exp_filter));

        // Gate edges on voice 2 and voice 0
        do_write(5'd18, 8'h41);
        exp_voice[18*8 +: 8] = 8'h41;
        check_val("rise_pulse", 192'(gate_rise), 192'(3'b100));
        check_val("rise_nofall", 192'(gate_fall), 192'(3'b000));
        check_val("ctrl_voice", 192'(voice_regs), 192'(exp_voice));
        tick();
        check_val("rise_onecyc", 192'(gate_rise), 192'(3'b000));
        do_write(5'd18, 8'h40);
        check_val("fall_pulse", 192'(gate_fall), 192'(3'b100));
        check_val("fall_norise", 192'(gate_rise), 192'(3'b000));
        do_write(5'd18, 8'h41);
        check_val("rise_again", 192'(gate_rise), 192'(3'b100));
        do_write(5'd18, 8'h41);
        check_val("same_norise", 192'(gate_rise), 192'(3'b000));
        check_val("same_nofall", 192'(gate_fall), 192'(3'b000));
        do_write(5'd4, 8'h01);
        check_val("rise_v0", 192'(gate_rise), 192'(3'b001));

        // Read on the same edge as a write sees the old latch value
        do_write(5'd1, 8'h12);
        w_en = 1'b1; w_addr = 5'd2; w_data = 8'h99;
        rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        w_en = 1'b0; rd_en = 1'b0;
        check_val("same_edge_valid", 192'(rd_valid), 192'(1'b1));
        check_val("same_edge_data", 192'(rd_data), 192'(8'h12));
        do_read("after_edge", 5'd5, 8'h99);

        // Reset beats a pending read and a gate-falling write
        rst = 1'b1; rd_en = 1'b1; rd_addr = 5'd25;
        w_en = 1'b1; w_addr = 5'd4; w_data = 8'h00;
        tick();
        rst = 1'b0; rd_en = 1'b0; w_en = 1'b0;
        exp_voice  = '0;
        exp_filter = 32'h0;
        check_val("rst_rd_valid", 192'(rd_valid), 192'(1'b0));
        check_val("rst_rd_data", 192'(rd_data), 192'(8'h00));
        check_val("rst2_voice", 192'(voice_regs), 192'(exp_voice));
        check_val("rst2_filter", 192'(filter_regs), 192'(exp_filter));
        check_val("rst2_gates", 192'({gate_rise, gate_fall}), 192'(6'b0));
        do_read("rst_latch", 5'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
